issue_scheduler: RTL and testbench
==================================

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL use one clock and an asynchronous active-low reset, named clk and rst_n.
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-003 SHALL have ports: dec_valid  in  1  decoded instr present; dec_class  in  2  0=AU,1=MUL,2=LSU,3=none; dec_rd/dec_rs1/dec_rs2  in  5 each  register indices; dec_use_rs1/dec_use_rs2  in  1 each  operand used.
REQ-004 SHALL have ports: au_free  in  3; mul_free  in  3; lsu_free  in  1  (unit idle, bit per unit).
REQ-005 SHALL have ports: wb_valid  in  1; wb_rd  in  5  (writeback retire); flush  in  1  jump/redirect kill.
REQ-006 SHALL have ports: dec_ready  out  1; au_issue  out  3; mul_issue  out  3; lsu_issue  out  1  (one-hot pulses); iss_rd/iss_rs1/iss_rs2  out  5 each; stall_cnt  out  16.

Function
REQ-007 SHALL accept an instruction when dec_valid && dec_ready in the same cycle.
REQ-008 SHALL drive dec_ready combinationally = !flush && class unit available && no hazard; class 3 always available (accepted, no issue pulse, no scoreboard set).
REQ-009 SHALL define unit available = (free bit && !reserved bit) for at least one unit of dec_class.
REQ-010 SHALL set a unit's reserved bit for exactly the cycle after it is issued, covering the free-signal drop latency.
REQ-011 SHALL detect hazard when (dec_use_rs1 && sb[dec_rs1]) || (dec_use_rs2 && sb[dec_rs2]) || sb[dec_rd], index 0 never busy.
REQ-012 SHALL evaluate hazards from the registered scoreboard only; no same-cycle writeback bypass.
REQ-013 SHALL, on accept, assert the chosen unit's issue bit for exactly one cycle starting the next cycle (latency 1), with iss_rd/rs1/rs2 registered alongside.
REQ-014 SHALL select among available AU (and MUL) units round-robin: per-class 2-bit pointer, search starts at pointer, pointer := granted index+1 mod 3 after a grant.
REQ-015 SHALL hold the pointer when the class is not granted; pointer values 3 never occur.
REQ-016 SHALL set sb[dec_rd] on accept when dec_rd != 0, visible from the next cycle.
REQ-017 SHALL clear sb[wb_rd] on wb_valid; set wins when set and clear target the same index in one cycle.
REQ-018 SHALL force dec_ready=0 while flush=1; scoreboard, pointers, and already-registered issue pulses unaffected.
REQ-019 SHALL keep issue outputs zero in every cycle not following an accept; at most one issue bit asserted across all vectors.
REQ-020 SHALL increment stall_cnt each cycle dec_valid && !dec_ready, saturating at 16'hFFFF.

Reset
REQ-021 SHALL on rst_n=0 asynchronously clear: scoreboard, reserved bits, issue vectors, iss_* fields, pointers (to 0), stall_cnt.
REQ-022 SHALL drop any in-flight accept when reset asserts mid-cycle; no issue pulse after deassertion.

Verification
REQ-023 SHALL cover: au_free=3'b111, three back-to-back AU accepts rd=1,2,3 -> au_issue 001,010,100 on cycles 1,2,3.
REQ-024 SHALL cover: accept rd=5, then instr with rs1=5 -> dec_ready=0, stall_cnt counts; wb_valid rd=5 -> dec_ready=1 one cycle later.
REQ-025 SHALL cover: same cycle accept rd=7 and wb_valid wb_rd=7 -> sb[7]=1 afterward.
REQ-026 SHALL cover: lsu_free=1 held high, two LSU instrs -> second stalls exactly one cycle (reservation), issues on cycle 3.
REQ-027 SHALL cover: flush=1 with dec_valid=1 -> no issue pulse, scoreboard unchanged; rst_n low mid-stream -> all outputs 0 immediately.
REQ-028 SHALL cover: dec_rd=0, rs1=0 sequence -> never stalls, sb[0] stays 0.

Source files
------------

// File: rtl/issue_scheduler_if.sv
// Decode-to-issue bundle for the issue scheduler.
// Master drives decode, unit status and writeback; slave is the scheduler.
interface issue_scheduler_if;
  logic       dec_valid;
  logic [1:0] dec_class;
  logic [4:0] dec_rd;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       dec_use_rs1;
  logic       dec_use_rs2;
  logic [2:0] au_free;
  logic [2:0] mul_free;
  logic       lsu_free;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       flush;
  logic       dec_ready;
  logic [2:0] au_issue;
  logic [2:0] mul_issue;
  logic       lsu_issue;
  logic [4:0] iss_rd;
  logic [4:0] iss_rs1;
  logic [4:0] iss_rs2;
  logic [15:0] stall_cnt;

  modport master (
    output dec_valid, dec_class, dec_rd,
    output dec_rs1, dec_rs2,
    output dec_use_rs1, dec_use_rs2,
    output au_free, mul_free, lsu_free,
    output wb_valid, wb_rd, flush,
    input  dec_ready, au_issue, mul_issue,
    input  lsu_issue, iss_rd, iss_rs1,
    input  iss_rs2, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_class, dec_rd,
    input  dec_rs1, dec_rs2,
    input  dec_use_rs1, dec_use_rs2,
    input  au_free, mul_free, lsu_free,
    input  wb_valid, wb_rd, flush,
    output dec_ready, au_issue, mul_issue,
    output lsu_issue, iss_rd, iss_rs1,
    output iss_rs2, stall_cnt
  );
endinterface

// File: rtl/issue_scheduler.sv
// In-order issue: scoreboard hazards, per-class
// round-robin unit pick, one-cycle issue pulses.
module issue_scheduler (
  input logic clk,
  input logic rst_n,
  issue_scheduler_if.slave bus
);
  logic [31:0] sb, sb_next;
  logic [1:0]  au_ptr, mul_ptr;
  logic [2:0]  au_pick, mul_pick;
  logic        unit_ok, hazard, accept;

  function automatic logic [2:0] rr_pick(
    input logic [2:0] avail,
    input logic [1:0] ptr
  );
    logic [2:0] pick;
    logic [1:0] idx;
    pick = '0;
    idx  = ptr;
    for (int k = 0; k < 3; k++) begin
      if (pick == '0 && avail[idx])
        pick[idx] = 1'b1;
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return pick;
  endfunction

  function automatic logic [1:0] ptr_after(
    input logic [2:0] g,
    input logic [1:0] ptr
  );
    logic [1:0] p;
    p = ptr;
    unique case (1'b1)
      g[0]:    p = 2'd1;
      g[1]:    p = 2'd2;
      g[2]:    p = 2'd0;
      default: p = ptr;
    endcase
    return p;
  endfunction

  // Issue vectors double as reservations: a unit just
  // issued is masked until its free line has dropped.
  always_comb begin
    au_pick  = rr_pick(bus.au_free & ~bus.au_issue, au_ptr);
    mul_pick = rr_pick(bus.mul_free & ~bus.mul_issue, mul_ptr);
    unit_ok  = 1'b0;
    case (bus.dec_class)
      2'd0:    unit_ok = |au_pick;
      2'd1:    unit_ok = |mul_pick;
      2'd2:    unit_ok = bus.lsu_free & ~bus.lsu_issue;
      default: unit_ok = 1'b1;
    endcase
  end

  always_comb begin
    hazard = sb[bus.dec_rd];
    if (bus.dec_use_rs1 && sb[bus.dec_rs1])
      hazard = 1'b1;
    if (bus.dec_use_rs2 && sb[bus.dec_rs2])
      hazard = 1'b1;
  end

  assign bus.dec_ready = !bus.flush && unit_ok && !hazard;
  assign accept = bus.dec_valid && bus.dec_ready;

  always_comb begin
    sb_next = sb;
    if (bus.wb_valid)
      sb_next[bus.wb_rd] = 1'b0;
    if (accept && bus.dec_class != 2'd3)
      sb_next[bus.dec_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb        <= '0;
      au_ptr    <= '0;
      mul_ptr   <= '0;
      bus.au_issue  <= '0;
      bus.mul_issue <= '0;
      bus.lsu_issue <= 1'b0;
      bus.iss_rd    <= '0;
      bus.iss_rs1   <= '0;
      bus.iss_rs2   <= '0;
      bus.stall_cnt <= '0;
    end else begin
      sb <= sb_next;
      bus.au_issue  <= '0;
      bus.mul_issue <= '0;
      bus.lsu_issue <= 1'b0;
      bus.iss_rd    <= '0;
      bus.iss_rs1   <= '0;
      bus.iss_rs2   <= '0;
      if (accept) begin
        bus.iss_rd  <= bus.dec_rd;
        bus.iss_rs1 <= bus.dec_rs1;
        bus.iss_rs2 <= bus.dec_rs2;
        case (bus.dec_class)
          2'd0: begin
            bus.au_issue <= au_pick;
            au_ptr <= ptr_after(au_pick, au_ptr);
          end
          2'd1: begin
            bus.mul_issue <= mul_pick;
            mul_ptr <= ptr_after(mul_pick, mul_ptr);
          end
          2'd2:    bus.lsu_issue <= 1'b1;
          default: ;
        endcase
      end
      if (bus.dec_valid && !bus.dec_ready &&
          bus.stall_cnt != 16'hFFFF)
        bus.stall_cnt <= bus.stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: hazards, round-robin,
// reservations, flush and async reset.
module tb_issue_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;

  issue_scheduler_if bus ();

  issue_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(
    input logic       v,
    input logic [1:0] c,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       u1
  );
    bus.dec_valid   = v;
    bus.dec_class   = c;
    bus.dec_rd      = rd;
    bus.dec_rs1     = rs1;
    bus.dec_rs2     = 5'd0;
    bus.dec_use_rs1 = u1;
    bus.dec_use_rs2 = 1'b0;
    #1;
  endtask

  task automatic wb(input logic [4:0] rd);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    step();
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.au_free  = 3'b000;
    bus.mul_free = 3'b000;
    bus.lsu_free = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_rd    = 5'd0;
    bus.flush    = 1'b0;
    drv(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_au", 16'(bus.au_issue), 16'h0);
    chk("rst_mul", 16'(bus.mul_issue), 16'h0);
    chk("rst_lsu", 16'(bus.lsu_issue), 16'h0);
    chk("rst_rd", 16'(bus.iss_rd), 16'h0);
    chk("rst_stall", bus.stall_cnt, 16'h0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // AU round-robin back-to-back
    bus.au_free = 3'b111;
    drv(1, 0, 1, 0, 0);
    chk("rr_rdy0", 16'(bus.dec_ready), 16'h1);
    step();
    chk("rr_au1", 16'(bus.au_issue), 16'h1);
    chk("rr_rd1", 16'(bus.iss_rd), 16'h1);
    drv(1, 0, 2, 0, 0);
    step();
    chk("rr_au2", 16'(bus.au_issue), 16'h2);
    drv(1, 0, 3, 0, 0);
    step();
    chk("rr_au3", 16'(bus.au_issue), 16'h4);
    chk("rr_rd3", 16'(bus.iss_rd), 16'h3);
    drv(0, 0, 0, 0, 0);
    step();
    chk("rr_idle", 16'(bus.au_issue), 16'h0);
    wb(1);
    wb(2);
    wb(3);

    // RAW hazard, no writeback bypass
    drv(1, 0, 5, 0, 0);
    chk("raw_rdy0", 16'(bus.dec_ready), 16'h1);
    step();
    drv(1, 0, 6, 5, 1);
    chk("raw_stall", 16'(bus.dec_ready), 16'h0);
    step();
    chk("raw_cnt1", bus.stall_cnt, 16'd1);
    chk("raw_noiss", 16'(bus.au_issue), 16'h0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    #1;
    chk("raw_nobyp", 16'(bus.dec_ready), 16'h0);
    step();
    bus.wb_valid = 1'b0;
    #1;
    chk("raw_cnt2", bus.stall_cnt, 16'd2);
    chk("raw_rdy1", 16'(bus.dec_ready), 16'h1);
    step();
    drv(0, 0, 0, 0, 0);
    chk("raw_au", 16'(bus.au_issue), 16'h2);
    chk("raw_rs1", 16'(bus.iss_rs1), 16'd5);
    chk("raw_rd", 16'(bus.iss_rd), 16'd6);
    wb(6);

    // set beats clear on same index
    drv(1, 0, 7, 0, 0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd7;
    #1;
    chk("sc_rdy", 16'(bus.dec_ready), 16'h1);
    step();
    bus.wb_valid = 1'b0;
    drv(0, 0, 7, 0, 0);
    chk("sc_busy", 16'(bus.dec_ready), 16'h0);
    chk("sc_au", 16'(bus.au_issue), 16'h4);
    wb(7);
    #1;
    chk("sc_clr", 16'(bus.dec_ready), 16'h1);

    // LSU reservation
    bus.lsu_free = 1'b1;
    drv(1, 2, 8, 0, 0);
    chk("lsu_rdy0", 16'(bus.dec_ready), 16'h1);
    step();
    drv(1, 2, 9, 0, 0);
    chk("lsu_iss1", 16'(bus.lsu_issue), 16'h1);
    chk("lsu_resv", 16'(bus.dec_ready), 16'h0);
    step();
    chk("lsu_gap", 16'(bus.lsu_issue), 16'h0);
    chk("lsu_rdy1", 16'(bus.dec_ready), 16'h1);
    chk("lsu_cnt", bus.stall_cnt, 16'd3);
    step();
    drv(0, 0, 0, 0, 0);
    chk("lsu_iss2", 16'(bus.lsu_issue), 16'h1);
    chk("lsu_rd", 16'(bus.iss_rd), 16'd9);
    wb(8);
    wb(9);

    // MUL pick skips busy and reserved units
    bus.mul_free = 3'b010;
    drv(1, 1, 10, 0, 0);
    chk("mul_rdy0", 16'(bus.dec_ready), 16'h1);
    step();
    chk("mul_iss1", 16'(bus.mul_issue), 16'h2);
    drv(1, 1, 11, 0, 0);
    chk("mul_resv", 16'(bus.dec_ready), 16'h0);
    bus.mul_free = 3'b011;
    #1;
    chk("mul_rdy1", 16'(bus.dec_ready), 16'h1);
    step();
    drv(0, 0, 0, 0, 0);
    chk("mul_iss2", 16'(bus.mul_issue), 16'h1);
    wb(10);
    wb(11);

    // flush kills accept, keeps scoreboard
    bus.flush = 1'b1;
    drv(1, 0, 12, 0, 0);
    chk("fl_rdy", 16'(bus.dec_ready), 16'h0);
    step();
    chk("fl_noiss", 16'(bus.au_issue), 16'h0);
    chk("fl_cnt", bus.stall_cnt, 16'd4);
    bus.flush = 1'b0;
    drv(0, 0, 12, 0, 0);
    chk("fl_nosb", 16'(bus.dec_ready), 16'h1);
    drv(1, 0, 13, 0, 0);
    step();
    bus.flush = 1'b1;
    drv(0, 0, 13, 0, 0);
    chk("fl_pulse", 16'(bus.au_issue), 16'h1);
    step();
    bus.flush = 1'b0;
    #1;
    chk("fl_sbkeep", 16'(bus.dec_ready), 16'h0);

    // async reset mid-cycle with accept in flight
    drv(1, 0, 14, 0, 0);
    chk("rs_rdy", 16'(bus.dec_ready), 16'h1);
    step();
    drv(1, 0, 15, 0, 0);
    chk("rs_pre", 16'(bus.au_issue), 16'h2);
    rst_n = 1'b0;
    #1;
    chk("rs_au", 16'(bus.au_issue), 16'h0);
    chk("rs_rd", 16'(bus.iss_rd), 16'h0);
    chk("rs_cnt", bus.stall_cnt, 16'h0);
    drv(0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("rs_nopulse", 16'(bus.au_issue), 16'h0);
    drv(0, 0, 13, 0, 0);
    chk("rs_sbclr", 16'(bus.dec_ready), 16'h1);

    // x0 never becomes busy
    drv(1, 0, 0, 0, 1);
    chk("x0_rdy0", 16'(bus.dec_ready), 16'h1);
    step();
    chk("x0_rdy1", 16'(bus.dec_ready), 16'h1);
    step();
    chk("x0_rdy2", 16'(bus.dec_ready), 16'h1);
    step();
    chk("x0_cnt", bus.stall_cnt, 16'h0);
    chk("x0_au", 16'(bus.au_issue), 16'h4);

    // class 3: accepted with no unit, no pulse, no sb
    bus.au_free = 3'b000;
    drv(1, 3, 20, 0, 0);
    chk("c3_rdy", 16'(bus.dec_ready), 16'h1);
    step();
    drv(0, 0, 20, 0, 0);
    chk("c3_au", 16'(bus.au_issue), 16'h0);
    chk("c3_mul", 16'(bus.mul_issue), 16'h0);
    chk("c3_lsu", 16'(bus.lsu_issue), 16'h0);
    bus.au_free = 3'b111;
    #1;
    chk("c3_nosb", 16'(bus.dec_ready), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
